seq_det_sched: RTL and testbench

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

---
 rtl/seq_det_sched_pkg.sv | 16 +
 rtl/seq_det_rr_arb.sv | 50 +++++
 rtl/seq_det_sched.sv | 146 ++++++++++++++
 tb/tb_seq_det_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_sched_pkg.sv
// Shared types and default sizing for the 1011 sequence-detector scheduler.
package seq_det_sched_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned FRAME_W_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/seq_det_rr_arb.sv
// Round-robin arbiter: one-hot grant from req_i, pointer advances past the winner on accept.
module seq_det_rr_arb
  import seq_det_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    accept_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o,
  output logic                    valid_o
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;
  int unsigned   sum;

  // Scan from the pointer upward with wrap; the first requester seen wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IW'(sum);
      if (!valid_o && req_i[idx]) begin
        valid_o    = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (accept_i && valid_o) begin
      ptr_q <= (gnt_idx_o == LAST) ? '0 : gnt_idx_o + IW'(1);
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Schedules requester frames serially through an external 1011 detector and counts matches.
// Optional SEQ_DET_SCHED_STICKY_EN adds per-requester sticky hit flags (hit_clr/hit_sticky).
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned FRAME_W = FRAME_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*FRAME_W-1:0]   frame,
  output logic [NREQ-1:0]           gnt,
  output logic                      det_clr,
  output logic                      det_in,
  input  logic                      det_out,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [CNT_W-1:0]          match_cnt
`ifdef SEQ_DET_SCHED_STICKY_EN
  ,
  input  logic [NREQ-1:0]           hit_clr,
  output logic [NREQ-1:0]           hit_sticky
`endif
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned BW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [IW-1:0]      id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]      done_id_q, done_id_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

  logic [NREQ-1:0]    arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic               idle;

  assign idle = (state_q == IDLE);

  seq_det_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i     (clk),
    .rst_ni    (rst),
    .req_i     (req),
    .accept_i  (idle),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .valid_o   (arb_valid)
  );

  // det_out lags det_in by one cycle, so DRAIN picks up the match on the last bit.
  assign cnt_inc = (det_out && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_d       = bit_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          sr_d    = FRAME_W'(frame >> (32'(arb_idx) * FRAME_W));
          id_d    = arb_idx;
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_inc;
        sr_d  = sr_q << 1;
        bit_d = bit_q + BW'(1);
        if (bit_q == LAST_BIT) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d       = cnt_inc;
        done_id_d   = id_q;
        match_cnt_d = cnt_inc;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_q       <= bit_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Grant is combinational from IDLE, so gate it with reset to keep it low while held.
  assign gnt       = (idle && rst) ? arb_gnt : '0;
  assign det_clr   = (state_q == CLR);
  assign det_in    = (state_q == SHIFT) && sr_q[FRAME_W-1];
  assign busy      = !idle;
  assign done      = (state_q == DONE);
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

`ifdef SEQ_DET_SCHED_STICKY_EN
  logic [NREQ-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q & ~hit_clr;
    if (done && (match_cnt_q != '0)) sticky_d[done_id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sticky_q <= '0;
    else      sticky_q <= sticky_d;
  end

  assign hit_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Randomized self-checking bench for seq_det_sched with a behavioural 1011 detector attached.
module tb_seq_det_sched;

  localparam int N   = 4;
  localparam int FW  = 8;
  localparam int FRW = N * FW;
  localparam int LAT = FW + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [FRW-1:0] frame;

  logic [N-1:0] gnt, gnt_s;
  logic         det_clr, det_in, det_out, det_clr_s, det_in_s, det_out_s;
  logic         busy, done, busy_s, done_s;
  logic [1:0]   done_id, done_id_s;
  logic [3:0]   match_cnt;
  logic [0:0]   match_cnt_s;

`ifdef SEQ_DET_SCHED_STICKY_EN
  logic [N-1:0] hit_clr, hit_sticky, hit_sticky_s, m_sticky;
`endif

  int errors = 0;
  int checks = 0;

  int cyc = 0, m_ptr = 0, m_g = 0, m_free = 0, m_id = 0, e_id = 0, e_cnt = 0, m_last_pick = -1;
  bit m_inflight = 1'b0;
  logic [FW-1:0] m_frame = '0;

  logic [N-1:0] obs_gnt;
  logic         obs_done;
  logic [1:0]   obs_id;
  logic [3:0]   obs_cnt;

  always #5 clk = ~clk;

  seq_det_sched #(.NREQ(N), .FRAME_W(FW), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .frame(frame), .gnt(gnt),
    .det_clr(det_clr), .det_in(det_in), .det_out(det_out),
    .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt)
`ifdef SEQ_DET_SCHED_STICKY_EN
    , .hit_clr(hit_clr), .hit_sticky(hit_sticky)
`endif
  );

  seq_det_sched #(.NREQ(N), .FRAME_W(FW), .CNT_W(1)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .frame(frame), .gnt(gnt_s),
    .det_clr(det_clr_s), .det_in(det_in_s), .det_out(det_out_s),
    .busy(busy_s), .done(done_s), .done_id(done_id_s), .match_cnt(match_cnt_s)
`ifdef SEQ_DET_SCHED_STICKY_EN
    , .hit_clr(hit_clr), .hit_sticky(hit_sticky_s)
`endif
  );

  // Overlapping 1011 detectors with a registered (Moore) match flag.
  logic [2:0] h_q, hs_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin h_q <= '0; det_out <= 1'b0; end
    else if (det_clr) begin h_q <= '0; det_out <= 1'b0; end
    else begin h_q <= {h_q[1:0], det_in}; det_out <= ({h_q, det_in} == 4'b1011); end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin hs_q <= '0; det_out_s <= 1'b0; end
    else if (det_clr_s) begin hs_q <= '0; det_out_s <= 1'b0; end
    else begin hs_q <= {hs_q[1:0], det_in_s}; det_out_s <= ({hs_q, det_in_s} == 4'b1011); end
  end

  function automatic int rr_pick(logic [N-1:0] r, int p);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      t = r >> j;
      if (t[0]) return j;
    end
    return -1;
  endfunction

  function automatic int count_1011(logic [FW-1:0] f);
    int c;
    logic [FW-1:0] t;
    c = 0;
    for (int i = 0; i <= FW - 4; i++) begin
      t = f >> (FW - 4 - i);
      if (t[3:0] == 4'b1011) c++;
    end
    return c;
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = v >> i;
      if (t[0]) return i;
    end
    return -1;
  endfunction

  task automatic set_slice(int i, logic [FW-1:0] v);
    frame = (frame & ~(FRW'({FW{1'b1}}) << (i * FW))) | (FRW'(v) << (i * FW));
  endtask

  task automatic model_reset();
    m_ptr = 0; m_free = cyc; m_inflight = 1'b0; e_id = 0; e_cnt = 0; m_last_pick = -1;
`ifdef SEQ_DET_SCHED_STICKY_EN
    m_sticky = '0;
`endif
  endtask

  // One clock: observe at negedge against the timeline model, then advance.
  task automatic step();
    logic [N-1:0]  eg;
    logic [FW-1:0] sh;
    int pick, k;
    bit idle, exp_clr, exp_din, exp_done;
    @(negedge clk);
    k    = cyc - m_g;
    idle = (cyc >= m_free);
    pick = idle ? rr_pick(req, m_ptr) : -1;
    eg   = (pick >= 0) ? (N'(1) << pick) : '0;
    exp_clr  = m_inflight && (k == 1);
    sh       = m_frame << (k - 2);
    exp_din  = (m_inflight && k >= 2 && k <= FW + 1) ? sh[FW-1] : 1'b0;
    exp_done = m_inflight && (k == LAT);
    if (exp_done) begin e_id = m_id; e_cnt = count_1011(m_frame); end
    obs_gnt = gnt; obs_done = done; obs_id = done_id; obs_cnt = match_cnt;

    checks++; if (gnt !== eg) begin errors++; $display("FAIL gnt cyc=%0d: got %b expected %b", cyc, gnt, eg); end
    checks++; if (gnt_s !== eg) begin errors++; $display("FAIL gnt_sat cyc=%0d: got %b expected %b", cyc, gnt_s, eg); end
    checks++; if (busy !== !idle) begin errors++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, !idle); end
    checks++; if (busy_s !== !idle) begin errors++; $display("FAIL busy_sat cyc=%0d: got %b expected %b", cyc, busy_s, !idle); end
    checks++; if (det_clr !== exp_clr) begin errors++; $display("FAIL det_clr cyc=%0d: got %b expected %b", cyc, det_clr, exp_clr); end
    checks++; if (det_in !== exp_din) begin errors++; $display("FAIL det_in cyc=%0d: got %b expected %b", cyc, det_in, exp_din); end
    checks++; if (done !== exp_done) begin errors++; $display("FAIL done cyc=%0d: got %b expected %b", cyc, done, exp_done); end
    checks++; if (done_s !== exp_done) begin errors++; $display("FAIL done_sat cyc=%0d: got %b expected %b", cyc, done_s, exp_done); end
    checks++; if (done_id !== 2'(e_id)) begin errors++; $display("FAIL done_id cyc=%0d: got %0d expected %0d", cyc, done_id, e_id); end
    checks++; if (done_id_s !== 2'(e_id)) begin errors++; $display("FAIL done_id_sat cyc=%0d: got %0d expected %0d", cyc, done_id_s, e_id); end
    checks++; if (match_cnt !== 4'(e_cnt)) begin errors++; $display("FAIL match_cnt cyc=%0d: got %0d expected %0d", cyc, match_cnt, e_cnt); end
    checks++; if (match_cnt_s !== 1'(e_cnt > 0)) begin errors++; $display("FAIL match_cnt_sat cyc=%0d: got %0d expected %0d", cyc, match_cnt_s, (e_cnt > 0)); end
`ifdef SEQ_DET_SCHED_STICKY_EN
    checks++; if (hit_sticky !== m_sticky) begin errors++; $display("FAIL hit_sticky cyc=%0d: got %b expected %b", cyc, hit_sticky, m_sticky); end
    m_sticky = m_sticky & ~hit_clr;
    if (exp_done && e_cnt > 0) m_sticky = m_sticky | (N'(1) << e_id);
`endif
    if (pick >= 0) begin
      m_g = cyc; m_free = cyc + LAT + 1; m_inflight = 1'b1; m_id = pick;
      m_frame = FW'(frame >> (pick * FW));
      m_ptr = (pick + 1) % N;
    end
    m_last_pick = pick;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_all_zero(string tag);
    checks++;
    if ({gnt, det_clr, det_in, busy, done, done_id, match_cnt, match_cnt_s, gnt_s, busy_s, done_s} !== '0) begin
      errors++;
      $display("FAIL %s: gnt=%b det_clr=%b det_in=%b busy=%b done=%b done_id=%0d match_cnt=%0d expected all 0",
               tag, gnt, det_clr, det_in, busy, done, done_id, match_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '1; frame = FRW'($urandom());
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    req = '1;
    for (int s = 0; s < 5 * (LAT + 1); s++) begin
      step();
      if (obs_gnt !== '0) begin
        order.push_back(oh_idx(obs_gnt));
        frame = FRW'($urandom());
      end
    end
    req = '0;
    checks++; if (order.size() != 5) begin errors++; $display("FAIL rr_grant_count: got %0d expected 5", order.size()); end
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]); end
    end
  endtask

  task automatic run_single(int idx, logic [FW-1:0] f, int expc);
    int g_at, c0;
    bit seen;
    g_at = -1; seen = 1'b0;
    req = N'(1) << idx;
    set_slice(idx, f);
    for (int s = 0; s < 3 * LAT && !seen; s++) begin
      c0 = cyc;
      step();
      if (obs_gnt !== '0) begin
        checks++; if (obs_gnt !== (N'(1) << idx)) begin errors++; $display("FAIL single_gnt: got %b expected %b", obs_gnt, N'(1) << idx); end
        g_at = c0; req = '0; frame = FRW'($urandom());
      end
      if (obs_done === 1'b1) begin
        seen = 1'b1;
        checks++; if (obs_cnt !== 4'(expc)) begin errors++; $display("FAIL single_cnt frame=%b: got %0d expected %0d", f, obs_cnt, expc); end
        checks++; if (obs_id !== 2'(idx)) begin errors++; $display("FAIL single_id: got %0d expected %0d", obs_id, idx); end
        checks++; if (c0 - g_at != LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", c0 - g_at, LAT); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL single_timeout: got no done expected done for req %0d", idx); end
  endtask

  task automatic test_directed();
    run_single(2, 8'b1011_0110, 2); step();
    run_single(0, 8'h00, 0);        step();
    run_single(1, 8'b1010_1011, 1); step();
    run_single(3, 8'b1011_1011, 2); step();
  endtask

  task automatic test_reset_mid_shift();
    bit seen, first;
    req = 4'b0001; frame = FRW'($urandom());
    for (int s = 0; s < 10; s++) begin
      step();
      if (obs_gnt !== '0) break;
    end
    req = '0;
    repeat (5) step();
    rst = 1'b0; req = 4'b0010;
    #1;
    check_all_zero("reset_mid_shift");
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      check_all_zero("reset_held");
      @(posedge clk); #1; cyc++;
    end
    rst = 1'b1;
    model_reset();
    seen = 1'b0; first = 1'b1;
    for (int s = 0; s < 3 * LAT && !seen; s++) begin
      step();
      if (obs_gnt !== '0 && first) begin
        first = 1'b0;
        checks++; if (obs_gnt !== 4'b0010) begin errors++; $display("FAIL post_reset_gnt: got %b expected 0010", obs_gnt); end
        req = '0;
      end
      if (obs_done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL post_reset_timeout: got no done expected done"); end
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] pend, bm;
    pend = '0;
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++) begin
        bm = N'(1) << i;
        if ((pend & bm) == '0) begin
          if ($urandom_range(0, 3) == 0) begin
            pend = pend | bm;
            set_slice(i, ($urandom_range(0, 2) == 0) ? 8'hBB : FW'($urandom()));
          end else begin
            set_slice(i, FW'($urandom()));
          end
        end
      end
      req = pend;
`ifdef SEQ_DET_SCHED_STICKY_EN
      hit_clr = ($urandom_range(0, 7) == 0) ? N'($urandom()) : '0;
`endif
      step();
      if (m_last_pick >= 0) pend = pend & ~(N'(1) << m_last_pick);
    end
    req = '0;
`ifdef SEQ_DET_SCHED_STICKY_EN
    hit_clr = '0;
`endif
    repeat (LAT + 2) step();
  endtask

`ifdef SEQ_DET_SCHED_STICKY_EN
  task automatic test_sticky();
    hit_clr = '0;
    run_single(1, 8'b1011_0110, 2); step();
    checks++; if (hit_sticky[1] !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b expected 1", hit_sticky[1]); end
    hit_clr = '1; step();
    hit_clr = '0; step();
    checks++; if (hit_sticky !== '0) begin errors++; $display("FAIL sticky_clr: got %b expected 0000", hit_sticky); end
    hit_clr = 4'b0010;
    run_single(1, 8'hBB, 2);
    hit_clr = '0; step();
    checks++; if (hit_sticky !== 4'b0010) begin errors++; $display("FAIL sticky_set_wins: got %b expected 0010", hit_sticky); end
    run_single(0, 8'h00, 0); step();
    checks++; if (hit_sticky[0] !== 1'b0) begin errors++; $display("FAIL sticky_no_match: got %b expected 0", hit_sticky[0]); end
  endtask
`endif

  initial begin
    rst = 1'b0; req = '0; frame = '0;
`ifdef SEQ_DET_SCHED_STICKY_EN
    hit_clr = '0; m_sticky = '0;
`endif
    test_reset();
    test_back_to_back();
    test_directed();
    test_reset_mid_shift();
    test_random();
`ifdef SEQ_DET_SCHED_STICKY_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
